// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional performance counters in instr_fetch are enabled by FETCH_PERF_EN.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    // Clears the byte-offset bits so redirect targets are word aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t with synchronous flush.
// The full flag is an internal overflow guard. The head reads as zero while
// the FIFO is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_data,
    output fetch_entry_t             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;
    fetch_entry_t     mem [DEPTH];

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; flush wins over push/pop.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage write.
    // NOTE: the storage array has no reset; pointers/count define validity and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: memory req/ack handshake, PC advance and redirect
// handling, feeding a prefetch FIFO toward decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_dropped counters.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic             addr_latch;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign imem_req   = (state == REQ) || (state == DROP);
    assign inst_valid = !fifo_empty;
    assign inst_out   = head.inst;
    assign inst_pc    = head.addr;
    assign pop        = inst_valid && inst_ready && !redirect;
    assign push_entry = '{addr: imem_addr, inst: imem_rdata};

    // Next-state, push and PC-update decode; redirect overrides the PC value.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        addr_latch = 1'b0;
        push       = 1'b0;
        pc_load    = 1'b0;
        pc_next    = '0;
        case (state)
            IDLE: begin
                if (!redirect && (fifo_count < CNT_W'(DEPTH))) begin
                    addr_latch = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    state_next = IDLE;
                    if (!redirect) begin
                        push    = 1'b1;
                        pc_load = 1'b1;
                        pc_next = imem_addr + PC_STEP;
                    end
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_ack && !redirect) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            pc_load = 1'b1;
            pc_next = redirect_addr & ALIGN_MASK;
        end
    end

    // State register and request address, held stable while a request is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            imem_addr <= '0;
        end else begin
            state <= state_next;
            if (addr_latch) imem_addr <= pc_addr;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .wr_data (push_entry),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

`ifdef FETCH_PERF_EN
    logic        drop_ack;
    logic [31:0] flushed;

    assign drop_ack = imem_ack && ((state == DROP) || ((state == REQ) && redirect));
    assign flushed  = redirect ? 32'(fifo_count) : 32'd0;

    // Fetch/drop counters; flushed entries add the occupancy at flush time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_dropped <= perf_dropped + 32'(drop_ack) + flushed;
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule
